alu_seq: RTL and testbench

Width-parametrised, multi-cycle successor to the 16-bit integer-datapath ALU.
- Keeps the 13 single-cycle operations at opcodes 0x0–0xC.
- Adds iterative unsigned multiply and arithmetic right shift by a variable amount.
- Adds an overflow flag and registers all results and flags.
- Valid/ready handshakes on input and output let the datapath controller issue operations and stall on multi-cycle results.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_core.sv | 59 +++++
 rtl/alu_seq.sv | 173 +++++++++++++++++
 tb/tb_alu_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and state types shared by the sequential ALU
package alu_pkg;

    typedef enum logic [3:0] {
        OP_PASS_S = 4'h0,
        OP_PASS_R = 4'h1,
        OP_INC    = 4'h2,
        OP_DEC    = 4'h3,
        OP_ADD    = 4'h4,
        OP_SUB    = 4'h5,
        OP_SRL    = 4'h6,
        OP_SLL    = 4'h7,
        OP_AND    = 4'h8,
        OP_OR     = 4'h9,
        OP_XOR    = 4'hA,
        OP_NOT    = 4'hB,
        OP_NEG    = 4'hC,
        OP_MUL    = 4'hD,
        OP_ASR    = 4'hE,
        OP_RSVD   = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational single-cycle op unit producing result, carry and overflow
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  opcode_t          i_op,
    input  logic [WIDTH-1:0] i_r,
    input  logic [WIDTH-1:0] i_s,
    output logic [WIDTH-1:0] o_y,
    output logic             o_c,
    output logic             o_v
);

    localparam int MSB = WIDTH - 1;

    // Bit WIDTH of w_sum is the carry/borrow/shifted-out bit
    logic [WIDTH:0] w_sum;

    always_comb begin
        w_sum = {1'b0, i_s};
        o_v   = 1'b0;
        case (i_op)
            OP_PASS_S: w_sum = {1'b0, i_s};
            OP_PASS_R: w_sum = {1'b0, i_r};
            OP_INC: begin
                w_sum = {1'b0, i_s} + (WIDTH+1)'(1);
                o_v   = ~i_s[MSB] & w_sum[MSB];
            end
            OP_DEC: begin
                w_sum = {1'b0, i_s} - (WIDTH+1)'(1);
                o_v   = i_s[MSB] & ~w_sum[MSB];
            end
            OP_ADD: begin
                w_sum = {1'b0, i_r} + {1'b0, i_s};
                o_v   = (i_r[MSB] == i_s[MSB]) && (w_sum[MSB] != i_r[MSB]);
            end
            OP_SUB: begin
                w_sum = {1'b0, i_r} - {1'b0, i_s};
                o_v   = (i_r[MSB] != i_s[MSB]) && (w_sum[MSB] != i_r[MSB]);
            end
            OP_SRL:  w_sum = {i_s[0], 1'b0, i_s[MSB:1]};
            OP_SLL:  w_sum = {i_s, 1'b0};
            OP_AND:  w_sum = {1'b0, i_r & i_s};
            OP_OR:   w_sum = {1'b0, i_r | i_s};
            OP_XOR:  w_sum = {1'b0, i_r ^ i_s};
            OP_NOT:  w_sum = {1'b0, ~i_s};
            OP_NEG: begin
                w_sum = {(WIDTH+1){1'b0}} - {1'b0, i_s};
                o_v   = i_s[MSB] & w_sum[MSB];
            end
            // MUL/ASR results come from the sequencer; here they degrade to pass S (ASR by 0)
            default: w_sum = {1'b0, i_s};
        endcase
        o_y = w_sum[MSB:0];
        o_c = w_sum[WIDTH];
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU with handshakes, iterative multiply and arithmetic shift
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int CNT_W   = $clog2(WIDTH) + 1;

    state_t               r_state;
    opcode_t              r_op;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     r_tgt;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_y;
    logic                 r_n;
    logic                 r_z;
    logic                 r_c;
    logic                 r_v;

    opcode_t              w_in_op;
    logic [SHAMT_W-1:0]   w_amt;
    logic [WIDTH-1:0]     w_core_y;
    logic                 w_core_c;
    logic                 w_core_v;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_last;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_nxt;
    logic [WIDTH-1:0]     w_asr_nxt;
    logic [WIDTH-1:0]     w_res_y;
    logic                 w_res_c;
    logic                 w_res_v;

    assign w_in_op = opcode_t'(alu_op);
    assign w_amt   = r[SHAMT_W-1:0];

    alu_core #(.WIDTH(WIDTH)) u_core (
        .i_op (w_in_op),
        .i_r  (r),
        .i_s  (s),
        .o_y  (w_core_y),
        .o_c  (w_core_c),
        .o_v  (w_core_v)
    );

    // Multiply: high half accumulates R while the multiplier drains out of the low half
    always_comb begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        w_last    = (w_cnt_nxt == r_tgt);
        w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
        w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
        w_asr_nxt = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
        w_res_y   = w_core_y;
        w_res_c   = w_core_c;
        w_res_v   = w_core_v;
        if (r_state == ST_BUSY) begin
            w_res_v = 1'b0;
            if (r_op == OP_MUL) begin
                w_res_y = w_mul_nxt[WIDTH-1:0];
                w_res_c = |w_mul_nxt[2*WIDTH-1:WIDTH];
            end else begin
                w_res_y = w_asr_nxt;
                w_res_c = r_acc[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_PASS_S;
            r_cnt       <= '0;
            r_tgt       <= '0;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_n         <= 1'b0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op  <= w_in_op;
                        r_cnt <= '0;
                        if (w_in_op == OP_MUL) begin
                            r_mcand    <= r;
                            r_acc      <= {{WIDTH{1'b0}}, s};
                            r_tgt      <= CNT_W'(WIDTH);
                            r_state    <= ST_BUSY;
                            r_in_ready <= 1'b0;
                        end else if (w_in_op == OP_ASR && w_amt != '0) begin
                            r_acc      <= {{WIDTH{1'b0}}, s};
                            r_tgt      <= {1'b0, w_amt};
                            r_state    <= ST_BUSY;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_y         <= w_res_y;
                            r_n         <= w_res_y[WIDTH-1];
                            r_z         <= (w_res_y == '0);
                            r_c         <= w_res_c;
                            r_v         <= w_res_v;
                            r_state     <= ST_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    r_cnt <= w_cnt_nxt;
                    if (r_op == OP_MUL) begin
                        r_acc <= w_mul_nxt;
                    end else begin
                        r_acc <= {{WIDTH{1'b0}}, w_asr_nxt};
                    end
                    if (w_last) begin
                        r_y         <= w_res_y;
                        r_n         <= w_res_y[WIDTH-1];
                        r_z         <= (w_res_y == '0);
                        r_c         <= w_res_c;
                        r_v         <= w_res_v;
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign n         = r_n;
    assign z         = r_z;
    assign c         = r_c;
    assign v         = r_v;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq at WIDTH=16
module tb_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alu_op;
    logic [W-1:0] r;
    logic [W-1:0] s;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         n;
    logic         z;
    logic         c;
    logic         v;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .r         (r),
        .s         (s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .n         (n),
        .z         (z),
        .c         (c),
        .v         (v)
    );

    typedef struct {
        logic [3:0]  op;
        logic [15:0] r;
        logic [15:0] s;
        int          lat;
        logic [15:0] y;
        logic        n;
        logic        z;
        logic        c;
        logic        v;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference built from arithmetic on wide integers, not from the datapath structure
    function automatic vec_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        vec_t   e;
        int     sa;
        int     sb;
        int     res;
        longint p;
        int     amt;
        sa    = int'($signed(a));
        sb    = int'($signed(b));
        e.op  = op;
        e.r   = a;
        e.s   = b;
        e.lat = 1;
        e.c   = 1'b0;
        e.v   = 1'b0;
        e.y   = b;
        case (op)
            4'h0: e.y = b;
            4'h1: e.y = a;
            4'h2: begin res = int'(b) + 1; e.y = res[15:0]; e.c = (res > 65535); e.v = (sb + 1 > 32767); end
            4'h3: begin res = int'(b) - 1; e.y = res[15:0]; e.c = (b == 16'd0); e.v = (sb - 1 < -32768); end
            4'h4: begin
                res = int'(a) + int'(b); e.y = res[15:0]; e.c = (res > 65535);
                e.v = (sa + sb > 32767) || (sa + sb < -32768);
            end
            4'h5: begin
                res = int'(a) - int'(b); e.y = res[15:0]; e.c = (a < b);
                e.v = (sa - sb > 32767) || (sa - sb < -32768);
            end
            4'h6: begin e.y = b >> 1; e.c = b[0]; end
            4'h7: begin e.y = b << 1; e.c = b[15]; end
            4'h8: e.y = a & b;
            4'h9: e.y = a | b;
            4'hA: e.y = a ^ b;
            4'hB: e.y = ~b;
            4'hC: begin res = 0 - int'(b); e.y = res[15:0]; e.c = (b != 16'd0); e.v = (-sb > 32767); end
            4'hD: begin
                p = longint'(a) * longint'(b); e.y = p[15:0]; e.c = ((p >> 16) != 0); e.lat = 17;
            end
            4'hE: begin
                amt = int'(a[3:0]);
                if (amt != 0) begin
                    e.y   = 16'($signed(b) >>> amt);
                    e.c   = b[amt-1];
                    e.lat = amt + 1;
                end
            end
            default: e.y = b;
        endcase
        e.n = e.y[15];
        e.z = (e.y == 16'd0);
        return e;
    endfunction

    task automatic run_vec(input vec_t e, input string tag);
        int cyc;
        int rdy_hi;
        cyc = 0;
        while (!in_ready && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, ".idle_ready"}, {31'd0, in_ready}, 32'd1);
        alu_op   = e.op;
        r        = e.r;
        s        = e.s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        alu_op   = 4'($urandom);
        r        = 16'($urandom);
        s        = 16'($urandom);
        cyc      = 1;
        rdy_hi   = 0;
        while (!out_valid && cyc < 64) begin
            if (in_ready) rdy_hi++;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, ".latency"}, cyc, e.lat);
        chk({tag, ".busy_ready"}, rdy_hi + int'(in_ready), 0);
        chk({tag, ".y"}, {16'd0, y}, {16'd0, e.y});
        chk({tag, ".nzcv"}, {28'd0, n, z, c, v}, {28'd0, e.n, e.z, e.c, e.v});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".release"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        vec_t e;
        logic [15:0] ra;
        logic [15:0] sb;
        logic [15:0] edge_vals [5];

        // op, r, s, latency, y, n, z, c, v
        tbl[0]  = '{4'h4, 16'hFFFF, 16'h0001,  1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{4'h5, 16'h8000, 16'h0001,  1, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{4'hC, 16'h0000, 16'h8000,  1, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{4'hD, 16'h0100, 16'h0101, 17, 16'h0100, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{4'hE, 16'h0004, 16'h8001,  5, 16'hF800, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{4'hE, 16'h0000, 16'h8001,  1, 16'h8001, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{4'h2, 16'h0000, 16'h7FFF,  1, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{4'h3, 16'h0000, 16'h0000,  1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{4'h6, 16'h0000, 16'h0003,  1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{4'h7, 16'h0000, 16'h8001,  1, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{4'hA, 16'hF0F0, 16'hF0F0,  1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{4'hF, 16'hFFFF, 16'h1234,  1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{4'hE, 16'h0011, 16'h0001,  2, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{4'hD, 16'hFFFF, 16'hFFFF, 17, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{4'hD, 16'h0000, 16'hBEEF, 17, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{4'hE, 16'h000F, 16'h8000, 16, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
        edge_vals[0] = 16'h0000;
        edge_vals[1] = 16'h0001;
        edge_vals[2] = 16'h7FFF;
        edge_vals[3] = 16'h8000;
        edge_vals[4] = 16'hFFFF;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_op    = 4'h0;
        r         = '0;
        s         = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.handshake", {30'd0, out_valid, in_ready}, 32'd1);
        chk("reset.y", {16'd0, y}, 32'd0);
        chk("reset.nzcv", {28'd0, n, z, c, v}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 300; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : 16'($urandom);
            sb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : 16'($urandom);
            e  = model(4'($urandom_range(0, 15)), ra, sb);
            run_vec(e, $sformatf("rnd%0d_op%h", i, e.op));
        end

        // Backpressure: result holds and a waiting request is not taken until released
        alu_op = 4'h4; r = 16'd2; s = 16'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        alu_op = 4'h5; r = 16'd10; s = 16'd3;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp.hold%0d.handshake", k), {30'd0, out_valid, in_ready}, 32'd2);
            chk($sformatf("bp.hold%0d.y", k), {16'd0, y}, 32'd5);
            chk($sformatf("bp.hold%0d.nzcv", k), {28'd0, n, z, c, v}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp.released", {30'd0, out_valid, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp.second.handshake", {30'd0, out_valid, in_ready}, 32'd2);
        chk("bp.second.y", {16'd0, y}, 32'd7);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset during the fifth cycle of a multiply
        alu_op = 4'hD; r = 16'd3; s = 16'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mulrst.busy", {30'd0, out_valid, in_ready}, 32'd0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("mulrst.handshake", {30'd0, out_valid, in_ready}, 32'd1);
        chk("mulrst.y", {16'd0, y}, 32'd0);
        chk("mulrst.nzcv", {28'd0, n, z, c, v}, 32'd0);
        run_vec('{4'h4, 16'd2, 16'd3, 1, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0}, "after_rst_add");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
